// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial A - B controller.
// A single full-subtractor cell is stepped LSB-first over WIDTH bits.
// Each result bit enters the result register from the MSB side.
// Define SUB_OVERFLOW_EN to add the signed-overflow output 'overflow'.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             barrow
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    bit_cnt;
  logic             br;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // The result register only needs WIDTH-1 bits.
  // The final bit goes straight to 'difference' on the last edge.
  logic [WIDTH-2:0] res;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // Shared full-subtractor cell operating on the current LSBs
  always_comb begin
    a_bit    = a_sh[0];
    b_bit    = b_sh[0];
    d_bit    = a_bit ^ b_bit ^ br;
    br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    res_next = {d_bit, res};
  end

  // Handshake outputs decode directly from the state register
  always_comb begin
    ready = (state != S_RUN);
    busy  = (state == S_RUN);
    done  = (state == S_DONE);
  end

  // Control FSM, datapath shifting and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      br         <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      difference <= '0;
      barrow     <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh    <= a_in;
            b_sh    <= b_in;
            br      <= 1'b0;
            bit_cnt <= '0;
            state   <= S_RUN;
          end else begin
            state   <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          res  <= res_next[WIDTH-1:1];
          if (bit_cnt == LAST_BIT) begin
            state      <= S_DONE;
            difference <= res_next;
            barrow     <= br_next;
`ifdef SUB_OVERFLOW_EN
            // On the last step the cell sees the operand and result sign bits
            overflow   <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: directed bench for serial_subtractor_ctrl (WIDTH=8).
// A transaction-level model predicts the outputs every cycle.
// Hand-computed literals pin the model at known points.
module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] difference;
  logic         barrow;
`ifdef SUB_OVERFLOW_EN
  logic         overflow;
`endif

  int checks = 0;
  int fails  = 0;
  int done_count = 0;
  bit check_en = 0;

  // Model state: cycles of work left, pending and visible results
  int           m_left = 0;
  bit           m_done = 0;
  logic [W-1:0] m_diff = '0;
  bit           m_bor  = 0;
  bit           m_ovf  = 0;
  logic [W-1:0] p_diff = '0;
  bit           p_bor  = 0;
  bit           p_ovf  = 0;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .barrow     (barrow)
`ifdef SUB_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a start accepted while ready finishes W edges later
  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 0;
      m_diff = '0;
      m_bor  = 0;
      m_ovf  = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = 0;
      if (m_left == 0) begin
        m_done = 1;
        m_diff = p_diff;
        m_bor  = p_bor;
        m_ovf  = p_ovf;
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_left = W;
        p_diff = a_in - b_in;
        p_bor  = (a_in < b_in);
        p_ovf  = ($signed(a_in) - $signed(b_in) > 127) ||
                 ($signed(a_in) - $signed(b_in) < -128);
      end
    end
  end

  // Per-cycle comparison against the model, shortly after each edge
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_count++;
    if (check_en) begin
      checkOutput("ready", ready, m_left == 0);
      checkOutput("busy", busy, m_left > 0);
      checkOutput("done", done, m_done);
      checkOutput("difference", difference, m_diff);
      checkOutput("barrow", barrow, m_bor);
`ifdef SUB_OVERFLOW_EN
      checkOutput("overflow", overflow, m_ovf);
`endif
    end
  end

  // Present a one-cycle start with operands; returns 1 time unit after the accepting edge
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
  endtask

  // Count edges until done appears; bounded so a stuck DUT still ends the run
  task automatic waitDone(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    for (int i = 0; i < 4 * W; i++) begin
      @(posedge clk);
      #2;
      edges++;
      if (done === 1'b1) return;
      if (busy === 1'b1) busy_cycles++;
    end
    checks++;
    fails++;
    $display("[TB] FAIL done_timeout: got no done, expected done within %0d edges", 4 * W);
  endtask

  logic [W-1:0] va [3] = '{8'h12, 8'h00, 8'hFF};
  logic [W-1:0] vb [3] = '{8'h35, 8'h01, 8'hFF};
  logic [W-1:0] vd [3] = '{8'hDD, 8'hFF, 8'h00};
  bit           vbr[3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    int n;
    int bc;
    int dc;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_ready", ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_difference", difference, 0);
    checkOutput("reset_barrow", barrow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_en = 1;

    // Basic subtraction, latency and busy length
    applyStimulus(8'h35, 8'h12);
    waitDone(n, bc);
    checkOutput("latency_edges", n, W);
    checkOutput("busy_cycles_after_accept", bc, W - 1);
    checkOutput("diff_35_12", difference, 8'h23);
    checkOutput("bor_35_12", barrow, 0);

    // Directed operand table
    for (int i = 0; i < 3; i++) begin
      applyStimulus(va[i], vb[i]);
      waitDone(n, bc);
      checkOutput("table_diff", difference, vd[i]);
      checkOutput("table_bor", barrow, vbr[i]);
    end

    // Start while busy must be ignored
    repeat (2) @(posedge clk);
    dc = done_count;
    applyStimulus(8'h35, 8'h12);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'h01;
    b_in  = 8'h02;
    @(negedge clk);
    start = 1'b0;
    waitDone(n, bc);
    repeat (W + 4) @(posedge clk);
    #2;
    checkOutput("ignored_diff", difference, 8'h23);
    checkOutput("ignored_bor", barrow, 0);
    checkOutput("ignored_done_pulses", done_count - dc, 1);

    // Back-to-back: start presented during the DONE cycle
    applyStimulus(8'h12, 8'h35);
    waitDone(n, bc);
    checkOutput("b2b_first_diff", difference, 8'hDD);
    start = 1'b1;
    a_in  = 8'h80;
    b_in  = 8'h7F;
    @(posedge clk);
    #1;
    start = 1'b0;
    #1;
    checkOutput("b2b_busy", busy, 1);
    checkOutput("b2b_held_diff", difference, 8'hDD);
    waitDone(n, bc);
    checkOutput("b2b_latency", n, W);
    checkOutput("b2b_diff", difference, 8'h01);
    checkOutput("b2b_bor", barrow, 0);

    // Reset mid-run aborts with no done pulse
    repeat (2) @(posedge clk);
    applyStimulus(8'h35, 8'h12);
    repeat (4) @(posedge clk);
    #1;
    dc = done_count;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("abort_diff", difference, 0);
    checkOutput("abort_bor", barrow, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ready", ready, 1);
    repeat (W + 4) @(posedge clk);
    #2;
    checkOutput("abort_no_done", done_count - dc, 0);
    applyStimulus(8'h0A, 8'h03);
    waitDone(n, bc);
    checkOutput("after_abort_diff", difference, 8'h07);
    checkOutput("after_abort_bor", barrow, 0);

`ifdef SUB_OVERFLOW_EN
    applyStimulus(8'h80, 8'h01);
    waitDone(n, bc);
    checkOutput("ovf_diff", difference, 8'h7F);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_bor", barrow, 0);
    applyStimulus(8'h05, 8'h03);
    waitDone(n, bc);
    checkOutput("noovf_flag", overflow, 0);
`endif

    repeat (3) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial subtractor controller. It computes A − B by stepping one subtractor bit cell (full-subtractor: a, b, borrow-in) LSB-first over WIDTH bits.
- Holds operand shift registers, the running borrow flop, a bit counter and a start/busy/done handshake.
- Used where area matters more than latency; the single-bit subtract cell is shared across all bit positions.

Parameters:
WIDTH, 8, operand and result width in bits (legal range ≥2).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request to begin a subtraction; accepted only when ready=1
a_in  input  WIDTH  minuend, captured on accepted start
b_in  input  WIDTH  subtrahend, captured on accepted start
ready  output  1  high in IDLE and DONE; start accepted
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse when result becomes valid
difference  output  WIDTH  A − B modulo 2^WIDTH, held until next accepted start
barrow  output  1  final borrow out (1 when A < B unsigned), held with difference

Behaviour:
- Reset (rst_n=0 at a clk edge), regardless of state:
  - state=IDLE, counter=0, borrow flop=0, operand registers=0.
  - difference=0, barrow=0, done=0, busy=0, ready=1.
- States:
  - IDLE → RUN on start=1. Captures a_in/b_in, clears the borrow flop, counter=0.
  - RUN: each cycle processes bit i = counter:
    - d_i = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - d_i is shifted into the result register from the MSB side; operand registers shift right by 1; counter increments.
  - RUN → DONE on the edge that processes bit WIDTH−1. difference and barrow are updated from the result register and final borrow on that same edge.
  - DONE → IDLE after one cycle. done=1 only in DONE. If start=1 in DONE, go directly to RUN and capture new operands (back-to-back).
- Latency: start sampled at edge k → busy high edges k+1..k+WIDTH → done high for the cycle following edge k+WIDTH. Total WIDTH+1 cycles from start to done.
- difference/barrow:
  - Change only on the RUN→DONE edge or on reset.
  - Not cleared by a new start.
  - Intermediate partial results are never visible on the outputs.
- start while busy=1: ignored. No effect on operands, counter or outputs; not queued.
- a_in/b_in are don't-care except on the accepted start edge.
- Reset mid-RUN: aborts the operation. Outputs go to reset values and no done pulse is generated.
- Counter width: $clog2(WIDTH); terminal count WIDTH−1, no wrap beyond it.

Optional Feature:
Macro SUB_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit): two's-complement signed overflow of A − B, computed as (a_msb ^ b_msb) & (a_msb ^ d_msb).
  - Updated on the same edge as difference; reset to 0; held with difference.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then start with a_in=0x35, b_in=0x12 (WIDTH=8) → done pulses exactly 9 cycles after start edge, difference=0x23, barrow=0, busy high for 8 cycles.
- a_in=0x12, b_in=0x35 → difference=0xDD, barrow=1; a_in=0x00, b_in=0x01 → difference=0xFF, barrow=1; a_in=0xFF, b_in=0xFF → difference=0x00, barrow=0.
- Start 0x35−0x12; pulse start with a_in=0x01, b_in=0x02 at cycle 3 of RUN → ignored; result 0x23/0 unchanged; exactly one done pulse.
- Back-to-back: start held high through DONE with new operands 0x80−0x7F → second run begins immediately, difference=0x01, barrow=0, done pulses 9 cycles after DONE cycle.
- Assert rst_n=0 for one cycle mid-RUN (after 4 bits) → difference=0, barrow=0, busy=0, ready=1 next cycle, no done pulse; a subsequent 0x0A−0x03 yields 0x07, barrow=0.
- With SUB_OVERFLOW_EN: 0x80−0x01 → difference=0x7F, overflow=1, barrow=0; 0x05−0x03 → overflow=0.
